mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 115 +++++++++++
 tb/tb_mem_copy_dma.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: reads src+idx, writes dst+idx, two cycles per word,
// with a running mod-2^DW checksum of the written words and word-boundary abort.
module mem_copy_dma #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clka,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [AW-1:0] src_r;
  logic [AW-1:0] dst_r;
  logic [AW:0]   len_r;
  logic [AW:0]   idx_r;
  logic [DW-1:0] data_r;
  logic [DW-1:0] sum_r;
  logic          abort_pend_r;
  logic          last_s;
  logic [AW-1:0] addr_s;

  assign last_s = ((idx_r + {{AW{1'b0}}, 1'b1}) == len_r);

  // Transfer sequencer: one READ/WRITE pair per word, abort honoured only after a WRITE
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      src_r        <= {AW{1'b0}};
      dst_r        <= {AW{1'b0}};
      len_r        <= {(AW+1){1'b0}};
      idx_r        <= {(AW+1){1'b0}};
      data_r       <= {DW{1'b0}};
      sum_r        <= {DW{1'b0}};
      abort_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            src_r        <= src_addr;
            dst_r        <= dst_addr;
            len_r        <= len;
            idx_r        <= {(AW+1){1'b0}};
            sum_r        <= {DW{1'b0}};
            abort_pend_r <= 1'b0;
            if (len != {(AW+1){1'b0}}) begin
              state_r <= ST_READ;
            end else begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          data_r  <= mem_douta;
          state_r <= ST_WRITE;
          // An abort seen mid-word is remembered so the paired write still happens
          if (abort) begin
            abort_pend_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          sum_r <= sum_r + data_r;
          idx_r <= idx_r + {{AW{1'b0}}, 1'b1};
          if (last_s || abort || abort_pend_r) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_READ;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory address: source or destination window offset by idx, parked at zero otherwise
  always_comb begin
    addr_s = {AW{1'b0}};
    case (state_r)
      ST_READ:  addr_s = src_r + idx_r[AW-1:0];
      ST_WRITE: addr_s = dst_r + idx_r[AW-1:0];
      default:  addr_s = {AW{1'b0}};
    endcase
  end

  assign mem_addra = addr_s;
  assign mem_wea   = (state_r == ST_WRITE);
  assign mem_dina  = data_r;
  assign busy      = (state_r == ST_READ) || (state_r == ST_WRITE);
  assign done      = (state_r == ST_DONE);
  assign checksum  = sum_r;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: a behavioural memory, directed transfers with
// hand-computed checksums/latencies, and a done-monitor popping the expectation queue.
module tb_mem_copy_dma;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = 8'h00;
  logic [AW-1:0] dst_addr = 8'h00;
  logic [AW:0]   len = 9'd0;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina;
  logic [DW-1:0] mem_douta;

  mem_copy_dma #(.DW(DW), .AW(AW)) dut (
    .clka(clka), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy), .done(done),
    .checksum(checksum), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  always #5 clka = ~clka;

  logic [DW-1:0] mem [0:255];
  logic          tb_we = 1'b0;
  logic          tb_clr = 1'b0;
  logic [7:0]    tb_a = 8'h00;
  logic [15:0]   tb_d = 16'h0000;

  always @(posedge clka) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (mem_wea) begin
      mem[mem_addra] <= mem_dina;
    end else if (tb_we) begin
      mem[tb_a] <= tb_d;
    end
  end
  assign mem_douta = mem[mem_addra];

  int cyc = 0;
  int wr_cnt = 0;
  always @(posedge clka) begin
    cyc <= cyc + 1;
    if (mem_wea) wr_cnt <= wr_cnt + 1;
  end

  typedef struct {
    logic [15:0] sum;
    int          cyc0;
    int          ncyc;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the start edge
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                       input logic [15:0] sum, input int ncyc, input string name);
    exp_t e;
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    e.sum = sum; e.cyc0 = cyc + 1; e.ncyc = ncyc; e.name = name;
    exp_q.push_back(e);
    @(negedge clka);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clka);
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clka);
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    tb_a  = a;
    tb_d  = d;
    tb_we = 1'b1;
    @(negedge clka);
    tb_we = 1'b0;
  endtask

  initial begin
    fork
      // Monitor: every done pulse is matched against the oldest pending expectation
      begin
        exp_t e;
        forever begin
          @(negedge clka);
          if (busy) busy_cnt++;
          if (rst_n && done) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk({e.name, "_sum"}, {16'h0000, checksum}, {16'h0000, e.sum});
              chk({e.name, "_cycle"}, cyc - e.cyc0 + 1, e.ncyc);
            end
          end
        end
      end
      begin
        int b0, w0;
        tb_clr = 1'b1;
        repeat (3) @(negedge clka);
        tb_clr = 1'b0;
        chk("rst_checksum", {16'h0000, checksum}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_wea", {31'd0, mem_wea}, 32'h0);
        chk("rst_addra", {24'd0, mem_addra}, 32'h0);
        chk("rst_dina", {16'd0, mem_dina}, 32'h0);
        rst_n = 1'b1;
        poke(8'h10, 16'h1111); poke(8'h11, 16'h2222);
        poke(8'h12, 16'h3333); poke(8'h13, 16'h4444);

        issue(8'h10, 8'h80, 9'd4, 16'hAAAA, 9, "copy4");
        wait_done();
        chk("copy4_m80", {16'd0, mem[8'h80]}, 32'h1111);
        chk("copy4_m81", {16'd0, mem[8'h81]}, 32'h2222);
        chk("copy4_m82", {16'd0, mem[8'h82]}, 32'h3333);
        chk("copy4_m83", {16'd0, mem[8'h83]}, 32'h4444);
        repeat (3) @(negedge clka);
        chk("checksum_hold", {16'd0, checksum}, 32'hAAAA);

        b0 = busy_cnt; w0 = wr_cnt;
        issue(8'h10, 8'h80, 9'd0, 16'h0000, 1, "len0");
        wait_done();
        chk("len0_busy", busy_cnt - b0, 32'd0);
        chk("len0_writes", wr_cnt - w0, 32'd0);

        poke(8'hFE, 16'h000A); poke(8'hFF, 16'h000B); poke(8'h00, 16'h000C);
        issue(8'hFE, 8'h01, 9'd3, 16'h0021, 7, "wrap");
        wait_done();
        chk("wrap_m01", {16'd0, mem[8'h01]}, 32'h000A);
        chk("wrap_m02", {16'd0, mem[8'h02]}, 32'h000B);
        chk("wrap_m03", {16'd0, mem[8'h03]}, 32'h000C);

        poke(8'h20, 16'h0001); poke(8'h21, 16'h0002); poke(8'h22, 16'h0003);
        issue(8'h20, 8'h21, 9'd3, 16'h0003, 7, "overlap");
        wait_done();
        chk("ovl_m21", {16'd0, mem[8'h21]}, 32'h0001);
        chk("ovl_m22", {16'd0, mem[8'h22]}, 32'h0001);
        chk("ovl_m23", {16'd0, mem[8'h23]}, 32'h0001);

        poke(8'h50, 16'hFFFF); poke(8'h51, 16'h0002);
        issue(8'h50, 8'h60, 9'd2, 16'h0001, 5, "trunc");
        wait_done();

        for (int i = 0; i < 8; i++) poke(8'h40 + i[7:0], 16'h0001 + i[15:0]);
        w0 = wr_cnt;
        issue(8'h40, 8'h90, 9'd8, 16'h0006, 7, "abort");
        repeat (4) @(negedge clka);
        abort = 1'b1;
        @(negedge clka);
        abort = 1'b0;
        wait_done();
        chk("abort_m90", {16'd0, mem[8'h90]}, 32'h0001);
        chk("abort_m91", {16'd0, mem[8'h91]}, 32'h0002);
        chk("abort_m92", {16'd0, mem[8'h92]}, 32'h0003);
        chk("abort_m93", {16'd0, mem[8'h93]}, 32'h0000);
        chk("abort_writes", wr_cnt - w0, 32'd3);

        issue(8'h10, 8'hA0, 9'd4, 16'hAAAA, 9, "rstmid");
        repeat (4) @(negedge clka);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_checksum", {16'h0000, checksum}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_wea", {31'd0, mem_wea}, 32'h0);
        chk("mid_rst_addra", {24'd0, mem_addra}, 32'h0);
        chk("mid_rst_dina", {16'd0, mem_dina}, 32'h0);
        exp_q.delete();
        @(negedge clka);
        rst_n = 1'b1;
        issue(8'h10, 8'hB0, 9'd2, 16'h3333, 5, "after_rst");
        wait_done();
        chk("rst_mA0", {16'd0, mem[8'hA0]}, 32'h1111);
        chk("rst_mA1", {16'd0, mem[8'hA1]}, 32'h2222);
        chk("rst_mA2", {16'd0, mem[8'hA2]}, 32'h0000);
        chk("rst_mA3", {16'd0, mem[8'hA3]}, 32'h0000);
        chk("after_mB0", {16'd0, mem[8'hB0]}, 32'h1111);
        chk("after_mB1", {16'd0, mem[8'hB1]}, 32'h2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end
endmodule
